vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen_pkg.sv | 58 +++++
 rtl/vga_sync_gen_if.sv | 25 ++
 rtl/vga_sync_gen_sync_delay_line.sv | 34 +++
 rtl/vga_sync_gen.sv | 114 +++++++++++
 tb/tb_vga_sync_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/vga_sync_gen_pkg.sv
// VGA timing constants, sync decode types and the decode helper.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package vga_sync_gen_pkg;

  // 640x480@60 timing, shared with the sync-to-count receiver.
  localparam int VGA_TOTAL_COLS    = 800;
  localparam int VGA_TOTAL_ROWS    = 525;
  localparam int VGA_ACTIVE_COLS   = 640;
  localparam int VGA_ACTIVE_ROWS   = 480;
  localparam int VGA_H_FRONT_PORCH = 16;
  localparam int VGA_H_SYNC        = 96;
  localparam int VGA_V_FRONT_PORCH = 10;
  localparam int VGA_V_SYNC        = 2;

  localparam int COUNT_W         = 10;
  localparam int MAX_SYNC_DELAY  = 7;

  typedef logic [COUNT_W-1:0] count_t;

  // IDLE holds (0,0) until the first enabled cycle after reset so that
  // cycle presents (0,0) with the frame strobe before counting starts.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } sync_t;

  // Value held while in reset: both syncs inactive (high), blanked.
  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

  function automatic sync_t sync_decode(
    input count_t col,
    input count_t row,
    input int     active_cols,
    input int     active_rows,
    input int     h_sync_start,
    input int     h_sync_len,
    input int     v_sync_start,
    input int     v_sync_len
  );
    sync_t s;
    int    c;
    int    r;
    c        = int'(col);
    r        = int'(row);
    s.hsync  = !((c >= h_sync_start) && (c < h_sync_start + h_sync_len));
    s.vsync  = !((r >= v_sync_start) && (r < v_sync_start + v_sync_len));
    s.active = (c < active_cols) && (r < active_rows);
    return s;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: pixel enable in, counts/syncs/strobe out.
// Latency: none (wiring only).
// Backpressure: i_En stalls the producer; there is no ready path.
interface vga_sync_gen_if;
  import vga_sync_gen_pkg::*;

  logic   i_En;
  count_t o_Col_Count;
  count_t o_Row_Count;
  logic   o_HSync;
  logic   o_VSync;
  logic   o_Active;
  logic   o_Frame_Start;

  modport master (
    input  i_En,
    output o_Col_Count, o_Row_Count, o_HSync, o_VSync, o_Active, o_Frame_Start
  );

  modport slave (
    output i_En,
    input  o_Col_Count, o_Row_Count, o_HSync, o_VSync, o_Active, o_Frame_Start
  );

endinterface

// File: rtl/vga_sync_gen_sync_delay_line.sv
// Enable-gated shift register used to lag the sync/active decode.
// Latency: DEPTH enabled cycles (DEPTH=0 is a straight wire).
// Backpressure: holds every stage when en is low.
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per enabled cycle; reset fills every stage with idle.
    always_ff @(posedge clk) begin
      if (!rst_l) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else if (en) begin
        stage_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counter with registered H/V sync, active and frame strobe.
// Latency: syncs track counts same cycle, or c_SYNC_DELAY enabled cycles later.
// Backpressure: i_En low freezes all state; no ready handshake.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int c_TOTAL_COLS    = VGA_TOTAL_COLS,
  parameter int c_TOTAL_ROWS    = VGA_TOTAL_ROWS,
  parameter int c_ACTIVE_COLS   = VGA_ACTIVE_COLS,
  parameter int c_ACTIVE_ROWS   = VGA_ACTIVE_ROWS,
  parameter int c_H_FRONT_PORCH = VGA_H_FRONT_PORCH,
  parameter int c_H_SYNC        = VGA_H_SYNC,
  parameter int c_V_FRONT_PORCH = VGA_V_FRONT_PORCH,
  parameter int c_V_SYNC        = VGA_V_SYNC,
  parameter int c_SYNC_DELAY    = 0
) (
  input  logic           i_Clk,
  input  logic           i_Rst_L,
  vga_sync_gen_if.master vid
);

  localparam int     H_SYNC_START = c_ACTIVE_COLS + c_H_FRONT_PORCH;
  localparam int     V_SYNC_START = c_ACTIVE_ROWS + c_V_FRONT_PORCH;
  localparam count_t LAST_COL     = count_t'(c_TOTAL_COLS - 1);
  localparam count_t LAST_ROW     = count_t'(c_TOTAL_ROWS - 1);

  if (H_SYNC_START + c_H_SYNC > c_TOTAL_COLS) begin : g_bad_h_timing
    $error("vga_sync_gen: horizontal active+porch+sync exceeds total");
  end
  if (V_SYNC_START + c_V_SYNC > c_TOTAL_ROWS) begin : g_bad_v_timing
    $error("vga_sync_gen: vertical active+porch+sync exceeds total");
  end
  if (c_SYNC_DELAY < 0 || c_SYNC_DELAY > MAX_SYNC_DELAY) begin : g_bad_delay
    $error("vga_sync_gen: c_SYNC_DELAY must be 0..7");
  end
  if (c_TOTAL_COLS > (1 << COUNT_W) || c_TOTAL_ROWS > (1 << COUNT_W)) begin : g_bad_width
    $error("vga_sync_gen: totals do not fit the 10-bit counters");
  end

  run_state_e state_q, state_d;
  count_t     col_q, col_d;
  count_t     row_q, row_d;
  sync_t      dec_q, dec_d;
  sync_t      sync_out;
  logic       fs_q, fs_d;

  // Run-state register; only enabled cycles move it.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L)      state_q <= ST_IDLE;
    else if (vid.i_En) state_q <= state_d;
  end

  // Next counts and the decode of those next counts, so the registered
  // decode lines up with the registered counts.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
        col_d   = '0;
        row_d   = '0;
      end
      ST_RUN: begin
        if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = (row_q == LAST_ROW) ? '0 : row_q + count_t'(1);
        end else begin
          col_d = col_q + count_t'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    dec_d = sync_decode(col_d, row_d, c_ACTIVE_COLS, c_ACTIVE_ROWS,
                        H_SYNC_START, c_H_SYNC, V_SYNC_START, c_V_SYNC);
    fs_d  = (col_d == '0) && (row_d == '0);
  end

  // Count, undelayed decode and frame strobe registers.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      col_q <= '0;
      row_q <= '0;
      dec_q <= SYNC_IDLE;
      fs_q  <= 1'b0;
    end else if (vid.i_En) begin
      col_q <= col_d;
      row_q <= row_d;
      dec_q <= dec_d;
      fs_q  <= fs_d;
    end
  end

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (c_SYNC_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay_line (
    .clk   (i_Clk),
    .rst_l (i_Rst_L),
    .en    (vid.i_En),
    .d     (dec_q),
    .q     (sync_out)
  );

  assign vid.o_Col_Count   = col_q;
  assign vid.o_Row_Count   = row_q;
  assign vid.o_HSync       = sync_out.hsync;
  assign vid.o_VSync       = sync_out.vsync;
  assign vid.o_Active      = sync_out.active;
  assign vid.o_Frame_Start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default timing with delay 0 and 3, plus a 20x12 raster
// for whole-frame, enable-toggling and mid-sync reset scenarios.
// All instances share clock, reset and enable.
module tb_vga_sync_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  always #5 clk = ~clk;

  vga_sync_gen_if bus0 ();
  vga_sync_gen_if bus3 ();
  vga_sync_gen_if bus_sm ();

  assign bus0.i_En   = en;
  assign bus3.i_En   = en;
  assign bus_sm.i_En = en;

  vga_sync_gen #(.c_SYNC_DELAY(0)) dut0 (.i_Clk(clk), .i_Rst_L(rst_n), .vid(bus0));
  vga_sync_gen #(.c_SYNC_DELAY(3)) dut3 (.i_Clk(clk), .i_Rst_L(rst_n), .vid(bus3));

  // Small raster: H sync low cols 14..16, V sync low rows 8..9, 240 pixels/frame.
  vga_sync_gen #(
    .c_TOTAL_COLS(20), .c_TOTAL_ROWS(12), .c_ACTIVE_COLS(12), .c_ACTIVE_ROWS(6),
    .c_H_FRONT_PORCH(2), .c_H_SYNC(3), .c_V_FRONT_PORCH(2), .c_V_SYNC(2),
    .c_SYNC_DELAY(0)
  ) dut_sm (.i_Clk(clk), .i_Rst_L(rst_n), .vid(bus_sm));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int   hs_low, vs_low, vs_bad, hold_bad, fs_cnt, clk_cnt;
    int   hs_first, act_fall, d3_hs_fall, d3_act_fall, prev_col;
    logic prev_act0, prev_hs3, prev_act3;

    // Reset state, with enable low then high.
    rst_n = 1'b0; en = 1'b0;
    tick(); tick();
    check("rst_col",    int'(bus0.o_Col_Count), 0);
    check("rst_row",    int'(bus0.o_Row_Count), 0);
    check("rst_hs",     int'(bus0.o_HSync), 1);
    check("rst_vs",     int'(bus0.o_VSync), 1);
    check("rst_act",    int'(bus0.o_Active), 0);
    check("rst_fs",     int'(bus0.o_Frame_Start), 0);
    check("rst_d3_hs",  int'(bus3.o_HSync), 1);
    check("rst_d3_act", int'(bus3.o_Active), 0);
    en = 1'b1;
    tick();
    check("rst_en_col", int'(bus0.o_Col_Count), 0);
    check("rst_en_fs",  int'(bus0.o_Frame_Start), 0);

    // First enabled cycle after release shows (0,0) with the strobe.
    rst_n = 1'b1;
    tick();
    check("first_col",    int'(bus0.o_Col_Count), 0);
    check("first_row",    int'(bus0.o_Row_Count), 0);
    check("first_fs",     int'(bus0.o_Frame_Start), 1);
    check("first_act",    int'(bus0.o_Active), 1);
    check("first_hs",     int'(bus0.o_HSync), 1);
    check("first_d3_act", int'(bus3.o_Active), 0);
    tick();
    check("second_col", int'(bus0.o_Col_Count), 1);
    check("second_fs",  int'(bus0.o_Frame_Start), 0);

    // Scan the rest of line 0 at default timing.
    hs_low = 0; hs_first = -1; act_fall = -1; d3_hs_fall = -1; d3_act_fall = -1;
    prev_act0 = bus0.o_Active; prev_hs3 = bus3.o_HSync; prev_act3 = bus3.o_Active;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!bus0.o_HSync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(bus0.o_Col_Count);
      end
      if (prev_act0 && !bus0.o_Active && act_fall < 0) act_fall = int'(bus0.o_Col_Count);
      if (prev_hs3 && !bus3.o_HSync && d3_hs_fall < 0) d3_hs_fall = int'(bus0.o_Col_Count);
      if (prev_act3 && !bus3.o_Active && d3_act_fall < 0) d3_act_fall = int'(bus0.o_Col_Count);
      prev_act0 = bus0.o_Active; prev_hs3 = bus3.o_HSync; prev_act3 = bus3.o_Active;
      if (bus0.o_Col_Count == 10'd0) break;
    end
    check("h_low_width",     hs_low, 96);
    check("h_first_low_col", hs_first, 656);
    check("act_fall_col",    act_fall, 640);
    check("d3_hs_fall_col",  d3_hs_fall, 659);
    check("d3_act_fall_col", d3_act_fall, 643);
    check("line_wrap_col",   int'(bus0.o_Col_Count), 0);
    check("line_wrap_row",   int'(bus0.o_Row_Count), 1);

    // One full small frame with enable held high.
    rst_n = 1'b0; en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    fs_cnt = int'(bus_sm.o_Frame_Start);
    hs_low = 0; vs_low = 0; vs_bad = 0;
    for (int i = 1; i <= 240; i++) begin
      tick();
      if (bus_sm.o_Frame_Start) fs_cnt++;
      if (!bus_sm.o_HSync) hs_low++;
      if (!bus_sm.o_VSync) begin
        vs_low++;
        if (bus_sm.o_Row_Count != 10'd8 && bus_sm.o_Row_Count != 10'd9) vs_bad++;
      end
      if (i == 239) begin
        check("sm_last_col", int'(bus_sm.o_Col_Count), 19);
        check("sm_last_row", int'(bus_sm.o_Row_Count), 11);
        check("sm_last_act", int'(bus_sm.o_Active), 0);
      end
    end
    check("sm_frame_col",  int'(bus_sm.o_Col_Count), 0);
    check("sm_frame_row",  int'(bus_sm.o_Row_Count), 0);
    check("sm_wrap_fs",    int'(bus_sm.o_Frame_Start), 1);
    check("sm_wrap_act",   int'(bus_sm.o_Active), 1);
    check("sm_fs_pulses",  fs_cnt, 2);
    check("sm_hs_low",     hs_low, 36);
    check("sm_vs_low",     vs_low, 40);
    check("sm_vs_rows",    vs_bad, 0);

    // Enable toggling: counts move on every other clock only.
    rst_n = 1'b0; en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    clk_cnt = -1; hs_low = 0; vs_low = 0; hold_bad = 0;
    prev_col = int'(bus_sm.o_Col_Count);
    for (int c = 1; c <= 600; c++) begin
      en = ((c % 2) == 0);
      tick();
      if (!en && int'(bus_sm.o_Col_Count) != prev_col) hold_bad++;
      if (en) begin
        if (!bus_sm.o_HSync) hs_low++;
        if (!bus_sm.o_VSync) vs_low++;
        if (bus_sm.o_Col_Count == 10'd0 && bus_sm.o_Row_Count == 10'd0) begin
          clk_cnt = c;
          break;
        end
      end
      prev_col = int'(bus_sm.o_Col_Count);
    end
    en = 1'b1;
    check("tog_frame_clocks", clk_cnt, 480);
    check("tog_hold",         hold_bad, 0);
    check("tog_hs_low_en",    hs_low, 36);
    check("tog_vs_low_en",    vs_low, 40);

    // Reset in the middle of both sync pulses (col 15, row 9).
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    repeat (195) tick();
    check("mid_pre_col", int'(bus_sm.o_Col_Count), 15);
    check("mid_pre_row", int'(bus_sm.o_Row_Count), 9);
    check("mid_pre_hs",  int'(bus_sm.o_HSync), 0);
    check("mid_pre_vs",  int'(bus_sm.o_VSync), 0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_col", int'(bus_sm.o_Col_Count), 0);
    check("mid_rst_row", int'(bus_sm.o_Row_Count), 0);
    check("mid_rst_hs",  int'(bus_sm.o_HSync), 1);
    check("mid_rst_vs",  int'(bus_sm.o_VSync), 1);
    check("mid_rst_act", int'(bus_sm.o_Active), 0);
    check("mid_rst_fs",  int'(bus_sm.o_Frame_Start), 0);
    rst_n = 1'b1;
    tick();
    check("mid_rel_col", int'(bus_sm.o_Col_Count), 0);
    check("mid_rel_fs",  int'(bus_sm.o_Frame_Start), 1);
    check("mid_rel_hs",  int'(bus_sm.o_HSync), 1);
    tick();
    check("mid_next_col", int'(bus_sm.o_Col_Count), 1);
    check("mid_next_vs",  int'(bus_sm.o_VSync), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
